// File: rtl/binary_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock, MSB first; done pulses DIVIDEND_W+1 cycles after start is accepted.
// start is ignored while busy; optional divide-by-zero short-cut enabled by BINARY_DIVIDER_ZERO_CHECK_EN.
module binary_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DIVIDEND_W);
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dq;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    pr;

  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W:0]    pr_nxt;
  logic [DIVIDEND_W-1:0] dq_nxt;
  logic                  ge;

  // A set top bit in pr means the shifted value overflowed the window, so it is certainly >= divisor.
  always_comb begin
    shifted = {pr[DIVISOR_W-1:0], dq[DIVIDEND_W-1]};
    ge      = pr[DIVISOR_W] | (shifted >= {1'b0, dvs});
    pr_nxt  = ge ? (shifted - {1'b0, dvs}) : shifted;
    dq_nxt  = {dq[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      pr          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
`ifdef BINARY_DIVIDER_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
`ifdef BINARY_DIVIDER_ZERO_CHECK_EN
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else
`endif
            begin
              state <= RUN;
              busy  <= 1'b1;
              dq    <= dividend;
              dvs   <= divisor;
              pr    <= '0;
              cnt   <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dq  <= dq_nxt;
          pr  <= pr_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= dq_nxt;
            remainder <= pr_nxt[DIVISOR_W-1:0];
`ifdef BINARY_DIVIDER_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BINARY_DIVIDER_ZERO_CHECK_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_binary_divider.sv
// Directed-vector bench for binary_divider at default widths.
module tb_binary_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  binary_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Waits (bounded) for done; counts cycles since the accepting edge and cycles with busy high.
  task automatic wait_done(input bit clr_start, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (clr_start && cyc == 1) start = 1'b0;
      if (busy) bcnt++;
    end while (!done && cyc < 40);
  endtask

  task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er, input int ecyc, input logic edbz);
    int cyc, bcnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    wait_done(1'b1, cyc, bcnt);
    check({tag, " latency"}, cyc, ecyc);
    check({tag, " busy cycles"}, bcnt, ecyc - 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    @(negedge clk);
    check({tag, " done single"}, done, 0);
    check({tag, " quotient hold"}, quotient, eq);
  endtask

  initial begin
    int  cyc, bcnt;
    bit  seen_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_div("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 9, 1'b0);
    do_div("255/15", 8'd255, 4'd15, 8'd17, 4'd0, 9, 1'b0);
    do_div("5/9", 8'd5, 4'd9, 8'd0, 4'd5, 9, 1'b0);
    do_div("255/2", 8'd255, 4'd2, 8'd127, 4'd1, 9, 1'b0);
    do_div("0/5", 8'd0, 4'd5, 8'd0, 4'd0, 9, 1'b0);

    // start held high and operands changed mid-run; held start re-accepted in the DONE cycle
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        dividend = 8'd255;
        divisor  = 4'd1;
      end
    end while (!done && cyc < 40);
    check("held latency", cyc, 9);
    check("held quotient", quotient, 28);
    check("held remainder", remainder, 4);
    wait_done(1'b1, cyc, bcnt);
    check("b2b latency", cyc, 9);
    check("b2b busy cycles", bcnt, 8);
    check("b2b quotient", quotient, 255);
    check("b2b remainder", remainder, 0);

    // asynchronous reset in RUN cycle 4
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run busy", busy, 1);
    check("run done", done, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort no done", seen_done, 0);
    do_div("100/3", 8'd100, 4'd3, 8'd33, 4'd1, 9, 1'b0);

`ifdef BINARY_DIVIDER_ZERO_CHECK_EN
    do_div("100/0", 8'd100, 4'd0, 8'd255, 4'd0, 1, 1'b1);
    do_div("clear dbz", 8'd9, 4'd2, 8'd4, 4'd1, 9, 1'b0);
`else
    do_div("100/0", 8'd100, 4'd0, 8'd255, 4'd4, 9, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/binary_divider.md
BINARY_DIVIDER -- requirements
Module: binary_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 8: width of dividend and quotient; legal values 2..16.
REQ-002 Parameter DIVISOR_W, default 4: width of divisor and remainder; legal values 2..DIVIDEND_W.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 start  input  1: request a division; sampled only when busy=0.
REQ-006 dividend  input  DIVIDEND_W: unsigned dividend, captured on the accepting edge.
REQ-007 divisor  input  DIVISOR_W: unsigned divisor, captured on the accepting edge.
REQ-008 busy  output  1: high while iterating; start ignored while high.
REQ-009 done  output  1: single-cycle pulse marking valid quotient/remainder.
REQ-010 quotient  output  DIVIDEND_W: registered unsigned quotient.
REQ-011 remainder  output  DIVISOR_W: registered unsigned remainder.
REQ-012 div_by_zero  output  1: registered flag, valid with done; tied 0 when the feature is compiled out.

Function
REQ-013 Block SHALL implement restoring shift-subtract division, one quotient bit per clk, MSB first.
REQ-014 Partial remainder register SHALL be DIVISOR_W+1 bits wide; each step shifts in the next dividend bit, subtracts divisor if partial remainder >= divisor, sets quotient bit to 1 on subtract, else 0.
REQ-015 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after exactly DIVIDEND_W iterations; DONE->IDLE after one cycle, or DONE->RUN if start=1 in that cycle.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-017 Latency: start accepted at edge N -> done high in the cycle after edge N+DIVIDEND_W (9 cycles at default).
REQ-018 quotient, remainder, div_by_zero SHALL update only on the RUN->DONE transition and hold until the next completion.
REQ-019 start=1 while busy=1 SHALL be ignored; operands SHALL not be recaptured.
REQ-020 dividend/divisor changes after the accepting edge SHALL not affect the running result.
REQ-021 Results SHALL satisfy quotient*divisor+remainder = dividend and remainder < divisor for every nonzero divisor.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all working registers 0.
REQ-023 Reset during RUN SHALL abort the operation with no done pulse; first start after release begins a fresh division.

Configuration
REQ-024 Macro BINARY_DIVIDER_ZERO_CHECK_EN SHALL enable divide-by-zero detection.
REQ-025 Defined: divisor=0 at acceptance SHALL skip RUN (IDLE->DONE), done one cycle after accepting edge, quotient=all ones, remainder=0, div_by_zero=1; busy stays 0.
REQ-026 Defined: nonzero divisor SHALL clear div_by_zero at completion.
REQ-027 Undefined: divisor=0 SHALL run full DIVIDEND_W iterations, yielding quotient=all ones, remainder=dividend[DIVISOR_W-1:0]; div_by_zero constant 0.

Verification
REQ-028 Defaults, dividend=200, divisor=7, start pulse -> busy 8 cycles, done 1 cycle, quotient=28, remainder=4.
REQ-029 dividend=255, divisor=15 -> quotient=17, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-030 start held high plus operand change (255/1) during RUN of 200/7 -> result 28 r4 unaffected; held start accepted in DONE cycle -> back-to-back 255 r0, 9 cycles later.
REQ-031 rst_n pulsed low at RUN cycle 4 of 200/7 -> all outputs 0 immediately, no done; subsequent 100/3 -> quotient=33, remainder=1.
REQ-032 dividend=100, divisor=0: macro defined -> done next cycle, quotient=255, remainder=0, div_by_zero=1; undefined -> done after 8 RUN cycles, quotient=255, remainder=4, div_by_zero=0.
